// File: rtl/lift_car_controller.sv
`timescale 1ns/1ps
// Car motion and door sequencer for a collectively scheduled lift.
// Steps the car one floor at a time, opens the door at served floors and retires served requests.
module lift_car_controller #(
   parameter int N_FLOORS      = 12,
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] i_up_req_queue,
   input  logic [N_FLOORS-1:0] i_dn_req_queue,
   input  logic [N_FLOORS-1:0] i_flr_req_queue,
   output logic [N_FLOORS-1:0] o_flr_pos,
   output logic                o_up_clr,
   output logic                o_dn_clr,
   output logic                o_flr_clr,
   output logic                o_door_open,
   output logic                o_dir,
   output logic                o_moving
);

   localparam int TRV_W  = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DOOR_W = $clog2(DOOR_CYCLES);
   localparam logic [TRV_W-1:0]    TRV_LAST  = TRV_W'(TRAVEL_CYCLES - 1);
   localparam logic [DOOR_W-1:0]   DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
   localparam logic [N_FLOORS-1:0] FLOOR0    = {{(N_FLOORS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MOVE  = 2'd1,
      S_CHECK = 2'd2,
      S_DOOR  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                flip;
   logic [TRV_W-1:0]    trv_cnt;
   logic [TRV_W-1:0]    trv_cnt_nxt;
   logic [DOOR_W-1:0]   door_cnt;
   logic [DOOR_W-1:0]   door_cnt_nxt;
   logic [N_FLOORS-1:0] flr_pos_nxt;
   logic                dir_nxt;
   logic                up_clr_nxt;
   logic                dn_clr_nxt;
   logic                flr_clr_nxt;
   logic                door_open_nxt;
   logic                moving_nxt;

   logic [N_FLOORS-1:0] any_req;
   logic [N_FLOORS-1:0] below_mask;
   logic [N_FLOORS-1:0] above_mask;
   logic                any_above;
   logic                any_below;
   logic                up_here;
   logic                dn_here;
   logic                flr_here;
   logic                ahead;
   logic                behind;
   logic                same;
   logic                opp;
   logic                trv_last;
   logic                door_last;
   logic                at_end;

   // Position is one-hot, so subtracting one yields every floor strictly below the car.
   assign any_req    = i_up_req_queue | i_dn_req_queue | i_flr_req_queue;
   assign below_mask = o_flr_pos - FLOOR0;
   assign above_mask = ~(below_mask | o_flr_pos);
   assign any_above  = |(any_req & above_mask);
   assign any_below  = |(any_req & below_mask);
   assign up_here    = |(i_up_req_queue & o_flr_pos);
   assign dn_here    = |(i_dn_req_queue & o_flr_pos);
   assign flr_here   = |(i_flr_req_queue & o_flr_pos);
   assign ahead      = o_dir ? any_above : any_below;
   assign behind     = o_dir ? any_below : any_above;
   assign same       = flr_here | (o_dir ? up_here : dn_here);
   assign opp        = o_dir ? dn_here : up_here;
   assign trv_last   = (trv_cnt == TRV_LAST);
   assign door_last  = (door_cnt == DOOR_LAST);
   assign at_end     = o_dir ? o_flr_pos[N_FLOORS-1] : o_flr_pos[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         trv_cnt     <= '0;
         door_cnt    <= '0;
         o_flr_pos   <= FLOOR0;
         o_dir       <= 1'b1;
         o_up_clr    <= 1'b0;
         o_dn_clr    <= 1'b0;
         o_flr_clr   <= 1'b0;
         o_door_open <= 1'b0;
         o_moving    <= 1'b0;
      end else begin
         state       <= state_nxt;
         trv_cnt     <= trv_cnt_nxt;
         door_cnt    <= door_cnt_nxt;
         o_flr_pos   <= flr_pos_nxt;
         o_dir       <= dir_nxt;
         o_up_clr    <= up_clr_nxt;
         o_dn_clr    <= dn_clr_nxt;
         o_flr_clr   <= flr_clr_nxt;
         o_door_open <= door_open_nxt;
         o_moving    <= moving_nxt;
      end
   end

   // IDLE prefers the opposite-direction call at this floor over travel; CHECK prefers continuing.
   always_comb begin
      state_nxt = state;
      flip      = 1'b0;
      case (state)
         S_IDLE: begin
            if (same) begin
               state_nxt = S_DOOR;
            end else if (opp) begin
               flip      = 1'b1;
               state_nxt = S_DOOR;
            end else if (ahead) begin
               state_nxt = S_MOVE;
            end else if (behind) begin
               flip      = 1'b1;
               state_nxt = S_MOVE;
            end
         end
         S_MOVE: begin
            if (trv_last) begin
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (same) begin
               state_nxt = S_DOOR;
            end else if (ahead) begin
               state_nxt = S_MOVE;
            end else if (opp) begin
               flip      = 1'b1;
               state_nxt = S_DOOR;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_DOOR: begin
            if (door_last) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Clear pulses use the post-flip direction so the hall call actually answered is retired.
   always_comb begin
      dir_nxt     = o_dir ^ flip;
      flr_pos_nxt = o_flr_pos;
      if (state == S_MOVE && trv_last && !at_end) begin
         flr_pos_nxt = o_dir ? (o_flr_pos << 1) : (o_flr_pos >> 1);
      end

      trv_cnt_nxt = '0;
      if (state == S_MOVE && !trv_last) begin
         trv_cnt_nxt = trv_cnt + TRV_W'(1);
      end

      door_cnt_nxt = '0;
      if (state == S_DOOR && state_nxt == S_DOOR) begin
         door_cnt_nxt = door_cnt + DOOR_W'(1);
      end

      flr_clr_nxt   = (state_nxt == S_DOOR) && (state != S_DOOR);
      up_clr_nxt    = flr_clr_nxt & dir_nxt;
      dn_clr_nxt    = flr_clr_nxt & ~dir_nxt;
      door_open_nxt = (state_nxt == S_DOOR);
      moving_nxt    = (state_nxt == S_MOVE) || (state_nxt == S_CHECK);
   end

endmodule

// File: tb/tb_lift_car_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for lift_car_controller: a stop-sequence model predicts every door
// stop (floor, direction, clear pulses, cycle) and the monitor checks each one as it appears.
module tb_lift_car_controller;
   localparam int N  = 12;
   localparam int TC = 8;
   localparam int DC = 16;
   localparam int K_STOP  = 0;
   localparam int K_IDLE  = 1;
   localparam int K_RESET = 2;

   typedef struct {
      int kind;
      int floor;
      bit dir;
      int cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] q_up, q_dn, q_fl;
   logic [N-1:0] flr_pos;
   logic         up_clr, dn_clr, flr_clr, door_open, dir, moving;

   logic [N-1:0] ld_up, ld_dn, ld_fl;
   bit           ld_req, ld_ack;
   int           cyc;
   int           n_checks, n_fail;
   exp_t         expq[$];
   int           m_pos;
   bit           m_dir;

   lift_car_controller #(.N_FLOORS(N), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
      .clk(clk), .reset(reset),
      .i_up_req_queue(q_up), .i_dn_req_queue(q_dn), .i_flr_req_queue(q_fl),
      .o_flr_pos(flr_pos), .o_up_clr(up_clr), .o_dn_clr(dn_clr), .o_flr_clr(flr_clr),
      .o_door_open(door_open), .o_dir(dir), .o_moving(moving)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Request storage: loads a new batch on request, drops bits on clear pulses.
   always @(negedge clk or posedge reset) begin
      if (reset) begin
         q_up = '0; q_dn = '0; q_fl = '0;
         ld_ack = ld_req;
      end else if (ld_req != ld_ack) begin
         q_up = ld_up; q_dn = ld_dn; q_fl = ld_fl;
         ld_ack = ld_req;
      end else begin
         if (up_clr)  q_up = q_up & ~flr_pos;
         if (dn_clr)  q_dn = q_dn & ~flr_pos;
         if (flr_clr) q_fl = q_fl & ~flr_pos;
      end
   end

   function automatic void chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset) begin
         while (expq.size() > 0 && expq[0].kind != K_RESET) void'(expq.pop_front());
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rst_pos", int'(flr_pos), 1);
            chk("rst_dir", int'(dir), 1);
            chk("rst_door", int'(door_open), 0);
            chk("rst_moving", int'(moving), 0);
            chk("rst_clr", int'({up_clr, dn_clr, flr_clr}), 0);
         end
      end else if (up_clr || dn_clr || flr_clr) begin
         if (expq.size() == 0 || expq[0].kind != K_STOP) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_clear actual=pos %0h clr %b%b%b required=no pulse",
                     flr_pos, up_clr, dn_clr, flr_clr);
         end else begin
            e = expq.pop_front();
            chk("stop_pos", int'(flr_pos), 1 << e.floor);
            chk("stop_dir", int'(dir), int'(e.dir));
            chk("stop_up_clr", int'(up_clr), int'(e.dir));
            chk("stop_dn_clr", int'(dn_clr), int'(!e.dir));
            chk("stop_flr_clr", int'(flr_clr), 1);
            chk("stop_door", int'(door_open), 1);
            chk("stop_moving", int'(moving), 0);
            chk("stop_cycle", cyc, e.cyc);
         end
      end else if (!moving && !door_open && expq.size() > 0 && expq[0].kind == K_IDLE) begin
         e = expq.pop_front();
         chk("idle_pos", int'(flr_pos), 1 << e.floor);
         chk("idle_dir", int'(dir), int'(e.dir));
      end
   end

   function automatic bit beyond(input logic [N-1:0] a, input int p, input bit d);
      for (int i = 0; i < N; i++)
         if (a[i] && (d ? (i > p) : (i < p))) return 1'b1;
      return 1'b0;
   endfunction

   // Next stop under collective scheduling with the request set frozen.
   function automatic void next_stop(input int p, input bit d, input logic [N-1:0] u,
                                     input logic [N-1:0] dn, input logic [N-1:0] fl,
                                     output int f, output bit d2, output int k);
      logic [N-1:0] a;
      bit dd;
      a  = u | dn | fl;
      dd = d;
      f  = p; d2 = d; k = 0;
      if (fl[p] || (d ? u[p] : dn[p])) return;
      if (d ? dn[p] : u[p]) begin
         d2 = !d;
         return;
      end
      if (!beyond(a, p, dd)) dd = !dd;
      for (int j = 1; j < N; j++) begin
         f  = dd ? p + j : p - j;
         k  = j;
         d2 = dd;
         if (fl[f] || (dd ? u[f] : dn[f])) return;
         if (!beyond(a, f, dd)) begin
            d2 = !dd;
            return;
         end
      end
   endfunction

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n > 20000) begin
            $display("FAIL idle_timeout actual=busy required=idle");
            $fatal(1, "car never went idle");
         end
      end while (moving || door_open);
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while (expq.size() > 0) begin
         @(posedge clk);
         n++;
         if (n > limit) begin
            $display("FAIL drain_timeout actual=%0d pending required=0", expq.size());
            $fatal(1, "expected events never appeared");
         end
      end
   endtask

   task automatic start_batch(input logic [N-1:0] u, input logic [N-1:0] d, input logic [N-1:0] f);
      int t, fl, k;
      bit dr;
      logic [N-1:0] mu, md, mf;
      wait_idle();
      ld_up = u; ld_dn = d; ld_fl = f;
      ld_req = !ld_req;
      t  = cyc;
      mu = u; md = d; mf = f;
      for (int s = 0; s < 4 * N && (mu | md | mf) != '0; s++) begin
         next_stop(m_pos, m_dir, mu, md, mf, fl, dr, k);
         expq.push_back('{K_STOP, fl, dr, t + 1 + (TC + 1) * k});
         mf[fl] = 1'b0;
         if (dr) mu[fl] = 1'b0;
         else    md[fl] = 1'b0;
         m_pos = fl;
         m_dir = dr;
         t = t + 1 + (TC + 1) * k + DC;
      end
      expq.push_back('{K_IDLE, m_pos, m_dir, 0});
   endtask

   task automatic run_batch(input logic [N-1:0] u, input logic [N-1:0] d, input logic [N-1:0] f);
      start_batch(u, d, f);
      wait_drain(20000);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      expq.push_back('{K_RESET, 0, 1'b1, 0});
      repeat (3) @(posedge clk);
      wait_drain(10);
      #1;
      reset = 1'b0;
      m_pos = 0;
      m_dir = 1'b1;
   endtask

   initial begin
      int n;
      reset  = 1'b1;
      ld_req = 1'b0;
      ld_up = '0; ld_dn = '0; ld_fl = '0;
      m_pos = 0;
      m_dir = 1'b1;
      expq.push_back('{K_RESET, 0, 1'b1, 0});
      repeat (3) @(posedge clk);
      wait_drain(10);
      #1;
      reset = 1'b0;

      run_batch('0, '0, 12'h008);              // car call at 3 from reset
      run_batch(12'h800, '0, '0);              // top floor, stays at 0x800
      run_batch('0, '0, 12'h001);              // reversal down to 0
      apply_reset();
      run_batch(12'h001, '0, '0);              // up-hall at 0 while at 0
      run_batch('0, '0, 12'h004);              // to floor 2 going up
      run_batch('0, '0, 12'h022);              // car calls at 5 and 1
      run_batch('0, '0, 12'h004);              // back to 2, direction up
      run_batch('0, 12'h010, '0);              // down-hall at 4 only: flip at CHECK

      for (int b = 0; b < 20; b++) begin
         run_batch(N'($urandom & $urandom & $urandom),
                   N'($urandom & $urandom & $urandom),
                   N'($urandom & $urandom & $urandom));
      end

      // Reset while travelling between floors 6 and 7.
      apply_reset();
      start_batch('0, '0, 12'h400);
      n = 0;
      while (!(flr_pos == 12'h040 && moving)) begin
         @(posedge clk); #1;
         n++;
         if (n > 2000) begin
            $display("FAIL reach_floor6 actual=%0h required=40", flr_pos);
            $fatal(1, "car never reached floor 6");
         end
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      expq.push_back('{K_RESET, 0, 1'b1, 0});
      repeat (2) @(posedge clk);
      wait_drain(10);
      #1;
      reset = 1'b0;
      m_pos = 0;
      m_dir = 1'b1;
      run_batch(12'h010, '0, 12'h004);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
